// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared encodings for the memory port arbiter: FSM state codes
//               and MemLength access-size values.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_STROBE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // MemLength encoding
    localparam logic c_LEN_BYTE = 1'b0;
    localparam logic c_LEN_WORD = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin pick. A lone request wins
//               outright; when both request, the port named by i_ptr wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_valid,
    output logic       o_winner
);

    // Select the winning port from the request pair and the favour pointer
    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        case (i_req)
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = i_ptr;
            default: o_winner = 1'b0;
        endcase
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one external memory port between the CPU (port 0) and
//               the DMA/boot loader (port 1). Runs one transaction at a time
//               through IDLE -> SETUP -> STROBE -> DONE with round-robin
//               arbitration and a MemRdy timeout. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              Wr0,
    input  logic              Wr1,
    input  logic              Len0,
    input  logic              Len1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Done0,
    output logic              Done1,
    output logic              Err0,
    output logic              Err1,
    output logic [DATA_W-1:0] RData,
    output logic              Busy,
    output logic              Owner,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    output logic              MemEnable,
    output logic              MemRd,
    output logic              MemWr,
    output logic              MemLength,
    input  logic              MemRdy
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               r_ptr;
    logic               r_wr;
    logic               r_len;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_timeout;
    logic               w_win_valid;
    logic               w_winner;

    rr_arbiter2 u_rr (
        .i_req    ({Req1, Req0}),
        .i_ptr    (r_ptr),
        .o_valid  (w_win_valid),
        .o_winner (w_winner)
    );

    // Next-state logic; the timeout fires at the end of the TIMEOUT-th strobe cycle
    always_comb begin
        w_next    = r_state;
        w_timeout = (r_cnt == c_CNT_LAST);
        case (r_state)
            c_ST_IDLE:   if (w_win_valid) w_next = c_ST_SETUP;
            c_ST_SETUP:  w_next = c_ST_STROBE;
            c_ST_STROBE: if (MemRdy || w_timeout) w_next = c_ST_DONE;
            c_ST_DONE:   w_next = c_ST_IDLE;
            default:     w_next = c_ST_IDLE;
        endcase
    end

    // State register, request latches, timeout counter and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= c_ST_IDLE;
            r_ptr     <= 1'b0;
            r_wr      <= 1'b0;
            r_len     <= 1'b0;
            r_cnt     <= '0;
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            Done0     <= 1'b0;
            Done1     <= 1'b0;
            Err0      <= 1'b0;
            Err1      <= 1'b0;
            RData     <= '0;
            Busy      <= 1'b0;
            Owner     <= 1'b0;
            MemAddr   <= '0;
            MemWData  <= '0;
            MemEnable <= 1'b0;
            MemRd     <= 1'b0;
            MemWr     <= 1'b0;
            MemLength <= 1'b0;
        end else begin
            r_state   <= w_next;
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            Done0     <= 1'b0;
            Done1     <= 1'b0;
            Err0      <= 1'b0;
            Err1      <= 1'b0;
            Busy      <= (w_next != c_ST_IDLE);
            MemEnable <= (w_next == c_ST_SETUP) || (w_next == c_ST_STROBE);
            MemRd     <= (w_next == c_ST_STROBE) && !r_wr;
            MemWr     <= (w_next == c_ST_STROBE) && r_wr;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_win_valid) begin
                        Owner     <= w_winner;
                        r_wr      <= w_winner ? Wr1 : Wr0;
                        r_len     <= w_winner ? Len1 : Len0;
                        MemLength <= w_winner ? Len1 : Len0;
                        MemAddr   <= w_winner ? Addr1 : Addr0;
                        MemWData  <= w_winner ? WData1 : WData0;
                        Gnt0      <= !w_winner;
                        Gnt1      <= w_winner;
                    end
                end
                c_ST_SETUP: begin
                    r_cnt <= '0;
                end
                c_ST_STROBE: begin
                    if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + c_CNT_ONE;
                    if (MemRdy && !r_wr) begin
                        if (r_len == c_LEN_BYTE)
                            RData <= {{(DATA_W-8){1'b0}}, MemRData[7:0]};
                        else
                            RData <= MemRData;
                    end
                    // MemRdy takes priority over a simultaneous timeout
                    if (MemRdy || w_timeout) begin
                        Done0 <= !Owner;
                        Done1 <= Owner;
                        Err0  <= !Owner && !MemRdy;
                        Err1  <= Owner && !MemRdy;
                    end
                end
                c_ST_DONE: begin
                    r_ptr <= !Owner;
                end
                default: ;
            endcase
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Req0, Req1, Wr0, Wr1, Len0, Len1;
    logic [ADDR_W-1:0] Addr0, Addr1;
    logic [DATA_W-1:0] WData0, WData1;
    logic              Gnt0, Gnt1, Done0, Done1, Err0, Err1;
    logic [DATA_W-1:0] RData;
    logic              Busy, Owner;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemEnable, MemRd, MemWr, MemLength, MemRdy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req0      (Req0),
        .Req1      (Req1),
        .Wr0       (Wr0),
        .Wr1       (Wr1),
        .Len0      (Len0),
        .Len1      (Len1),
        .Addr0     (Addr0),
        .Addr1     (Addr1),
        .WData0    (WData0),
        .WData1    (WData1),
        .Gnt0      (Gnt0),
        .Gnt1      (Gnt1),
        .Done0     (Done0),
        .Done1     (Done1),
        .Err0      (Err0),
        .Err1      (Err1),
        .RData     (RData),
        .Busy      (Busy),
        .Owner     (Owner),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRData  (MemRData),
        .MemEnable (MemEnable),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .MemLength (MemLength),
        .MemRdy    (MemRdy)
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge and settle 1 ns past it
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_strobe;
        logic len_bad;

        Reset = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0; Wr0 = 1'b0; Wr1 = 1'b0; Len0 = 1'b0; Len1 = 1'b0;
        Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;
        MemRData = '0; MemRdy = 1'b0;

        // 1: reset held two cycles, then idle with no requests
        step(); step();
        chk("reset_ctl", {Gnt1, Gnt0, Done1, Done0, Err1, Err0, Busy, Owner,
                          MemEnable, MemRd, MemWr, MemLength}, 64'h0);
        chk("reset_rdata", RData, 64'h0);
        chk("reset_memaddr", MemAddr, 64'h0);
        chk("reset_memwdata", MemWData, 64'h0);
        Reset = 1'b0;
        step(); step();
        chk("idle_noreq", {Busy, MemEnable, Gnt0, Gnt1}, 64'h0);

        // 2: port 0 word read, MemRdy in the first strobe cycle
        Req0 = 1'b1; Wr0 = 1'b0; Len0 = 1'b1; Addr0 = 32'h100;
        step();
        chk("t2_gnt", {Gnt0, Gnt1, Busy, MemEnable, MemRd, MemLength, Owner}, 64'b1011010);
        chk("t2_addr", MemAddr, 64'h100);
        Req0 = 1'b0;
        step();
        chk("t2_strobe", {Gnt0, MemEnable, MemRd, MemWr}, 64'b0110);
        MemRdy = 1'b1; MemRData = 32'hDEADBEEF;
        step();
        chk("t2_done", {Done0, Done1, Err0, MemRd, MemEnable}, 64'b10000);
        chk("t2_rdata", RData, 64'hDEADBEEF);
        MemRdy = 1'b0; MemRData = '0;
        step();
        chk("t2_idle", {Done0, Busy}, 64'b00);
        chk("t2_rdata_hold", RData, 64'hDEADBEEF);

        // 3: both request and hold; pointer reset so grants go 0,1,0,1
        Reset = 1'b1;
        step(); step();
        Reset = 1'b0;
        Req0 = 1'b1; Req1 = 1'b1; Wr0 = 1'b0; Wr1 = 1'b0; Len0 = 1'b1; Len1 = 1'b1;
        Addr0 = 32'h10; Addr1 = 32'h20;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t3_gnt%0d", k), {Gnt1, Gnt0, Owner},
                (k % 2 == 0) ? 64'b010 : 64'b101);
            step();
            MemRdy = 1'b1; MemRData = 32'h1000 + k;
            step();
            chk($sformatf("t3_done%0d", k), {Done1, Done0, Err1, Err0},
                (k % 2 == 0) ? 64'b0100 : 64'b1000);
            chk($sformatf("t3_rdata%0d", k), RData, 64'h1000 + k);
            MemRdy = 1'b0; MemRData = '0;
            step();
        end
        Req0 = 1'b0; Req1 = 1'b0;

        // 4: port 1 byte write, memory never ready -> timeout error
        Req1 = 1'b1; Wr1 = 1'b1; Len1 = 1'b0; Addr1 = 32'h200; WData1 = 32'h12345678;
        step();
        chk("t4_gnt", {Gnt1, Gnt0, MemLength}, 64'b100);
        chk("t4_wdata", MemWData, 64'h12345678);
        Req1 = 1'b0;
        step();
        n_strobe = 0;
        len_bad  = 1'b0;
        while (MemWr === 1'b1 && n_strobe < 40) begin
            n_strobe++;
            if (MemLength !== 1'b0 || MemRd !== 1'b0 || Done1 !== 1'b0) len_bad = 1'b1;
            step();
        end
        chk("t4_strobe_cycles", n_strobe, TIMEOUT);
        chk("t4_strobe_sigs", len_bad, 64'h0);
        chk("t4_done_err", {Done1, Err1, Done0, Err0, MemLength, MemEnable}, 64'b110000);
        chk("t4_rdata_unchanged", RData, 64'h1003);
        step();
        chk("t4_idle", {Done1, Err1, Busy}, 64'b000);

        // 5a: port 0 byte read -> zero-extended low byte
        Req0 = 1'b1; Wr0 = 1'b0; Len0 = 1'b0; Addr0 = 32'h300;
        step();
        chk("t5a_gnt", {Gnt0, Gnt1, MemLength}, 64'b100);
        Req0 = 1'b0;
        step();
        MemRdy = 1'b1; MemRData = 32'hAABBCCDD;
        step();
        chk("t5a_done", {Done0, Err0}, 64'b10);
        chk("t5a_rdata", RData, 64'h000000DD);
        MemRdy = 1'b0; MemRData = '0;
        step();

        // 5b: MemRdy in the same cycle the timeout would fire -> no error
        Req1 = 1'b1; Wr1 = 1'b0; Len1 = 1'b1; Addr1 = 32'h400;
        step();
        chk("t5b_gnt", {Gnt1, Gnt0}, 64'b10);
        Req1 = 1'b0;
        step();
        for (int i = 1; i < TIMEOUT; i++) step();
        chk("t5b_last_strobe", {MemRd, Done1}, 64'b10);
        MemRdy = 1'b1; MemRData = 32'h5A5A5A5A;
        step();
        chk("t5b_done_ok", {Done1, Err1}, 64'b10);
        chk("t5b_rdata", RData, 64'h5A5A5A5A);
        MemRdy = 1'b0; MemRData = '0;
        step();

        // 6: reset during strobe aborts silently; pending request re-granted
        Req0 = 1'b1; Wr0 = 1'b0; Len0 = 1'b1; Addr0 = 32'h500;
        step();
        chk("t6_gnt", Gnt0, 64'h1);
        step();
        chk("t6_strobe", MemRd, 64'h1);
        Reset = 1'b1;
        step();
        chk("t6_abort", {MemRd, MemWr, MemEnable, Busy, Done0, Err0, Gnt0}, 64'h0);
        Reset = 1'b0;
        step();
        chk("t6_regrant", {Gnt0, Busy, MemAddr == 32'h500}, 64'b111);
        Req0 = 1'b0;
        step();
        MemRdy = 1'b1; MemRData = 32'hCAFEF00D;
        step();
        chk("t6_done", {Done0, Err0}, 64'b10);
        chk("t6_rdata", RData, 64'hCAFEF00D);
        MemRdy = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
